// File: rtl/pc_flag_unit.sv
// pc_flag_unit: PC sequencer with branch-target LUT and flag/overflow registers; define RELATIVE_BRANCH_EN for PC-relative branches
module pc_flag_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              HALT_REQ,
  input  logic              BRANCH_EN,
  input  logic [LUT_AW-1:0] BR_IDX,
  input  logic              BR_REL,
  input  logic              FLAG_WE,
  input  logic              FLAG_D,
  input  logic              OVF_WE,
  input  logic              OVF_D,
  input  logic              LUT_WE,
  input  logic [LUT_AW-1:0] LUT_WADDR,
  input  logic [PC_W-1:0]   LUT_WDATA,
  output logic [PC_W-1:0]   PC,
  output logic              FLAG_Q,
  output logic              OVF_Q,
  output logic              INSTR_VALID,
  output logic              BR_TAKEN,
  output logic              DONE
);
  typedef enum logic [1:0] {IDLE, RUN, BUBBLE, HALT} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, target;
  logic [PC_W-1:0] lut_q [2**LUT_AW];
  logic flag_q, flag_d, ovf_q, ovf_d, lut_wr;
`ifdef RELATIVE_BRANCH_EN
  assign target = BR_REL ? pc_q + lut_q[BR_IDX] : lut_q[BR_IDX];
`else
  logic unused_br_rel;
  assign unused_br_rel = BR_REL;
  assign target = lut_q[BR_IDX];
`endif
  assign lut_wr = LUT_WE && (state_q == IDLE || state_q == HALT);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: state_d = START ? RUN : IDLE;
      RUN: begin
        flag_d  = FLAG_WE ? FLAG_D : flag_q;
        ovf_d   = OVF_WE ? OVF_D : ovf_q;
        state_d = HALT_REQ ? HALT : BRANCH_EN ? BUBBLE : RUN;
        pc_d    = HALT_REQ ? pc_q : BRANCH_EN ? target : pc_q + PC_W'(1);
      end
      BUBBLE: state_d = RUN;
      HALT: begin
        state_d = START ? RUN : HALT;
        pc_d    = START ? '0 : pc_q;
        flag_d  = START ? 1'b0 : flag_q;
        ovf_d   = START ? 1'b0 : ovf_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      pc_q    <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 2**LUT_AW; i++) lut_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
      if (lut_wr) lut_q[LUT_WADDR] <= LUT_WDATA;
    end
  end
  assign PC          = pc_q;
  assign FLAG_Q      = flag_q;
  assign OVF_Q       = ovf_q;
  assign INSTR_VALID = state_q == RUN;
  assign BR_TAKEN    = state_q == BUBBLE;
  assign DONE        = state_q == HALT;
endmodule

// File: doc/pc_flag_unit.md
PC_FLAG_UNIT -- requirements
Module: pc_flag_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10: program counter width in bits.
REQ-002 SHALL have parameter LUT_AW, default 4: branch-target LUT address width (2^LUT_AW entries, PC_W bits each).
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port START  in  1  start/restart request.
REQ-006 SHALL have port HALT_REQ  in  1  decoded halt instruction.
REQ-007 SHALL have port BRANCH_EN  in  1  ALU branch-enable (FLAG_BRANCH_EN).
REQ-008 SHALL have port BR_IDX  in  LUT_AW  branch-target LUT index from the instruction.
REQ-009 SHALL have port BR_REL  in  1  1 = PC-relative target, 0 = absolute target.
REQ-010 SHALL have ports FLAG_WE / FLAG_D  in  1 / 1  flag register write enable and data (ALU FLAG_OUT).
REQ-011 SHALL have ports OVF_WE / OVF_D  in  1 / 1  overflow register write enable and data (ALU OVERFLOW_OUT).
REQ-012 SHALL have ports LUT_WE / LUT_WADDR / LUT_WDATA  in  1 / LUT_AW / PC_W  LUT write port.
REQ-013 SHALL have port PC  out  PC_W  current instruction address.
REQ-014 SHALL have ports FLAG_Q / OVF_Q  out  1 / 1  registered flag and overflow, fed back to ALU FLAG_IN / OVERFLOW_IN.
REQ-015 SHALL have ports INSTR_VALID / BR_TAKEN / DONE  out  1 / 1 / 1  instruction at PC is live / taken-branch pulse / program halted.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, BUBBLE, HALT; all outputs registered or decoded from state only.
REQ-017 IDLE: INSTR_VALID=0, DONE=0, PC=0; START=1 -> RUN next cycle.
REQ-018 RUN: INSTR_VALID=1; priority HALT_REQ > BRANCH_EN > sequential.
REQ-019 RUN with HALT_REQ=1: PC holds, next state HALT, even if BRANCH_EN=1 the same cycle.
REQ-020 RUN with BRANCH_EN=1 (no halt): PC <= target, BR_TAKEN=1 for exactly the following cycle, next state BUBBLE.
REQ-021 RUN otherwise: PC <= PC+1, wrapping from 2^PC_W-1 to 0 without flagging.
REQ-022 Absolute target SHALL be LUT[BR_IDX]; relative target SHALL be (PC + LUT[BR_IDX]) mod 2^PC_W, LUT entry treated as two's-complement.
REQ-023 BUBBLE: INSTR_VALID=0, PC holds, FLAG_WE/OVF_WE/HALT_REQ/BRANCH_EN ignored, next state RUN.
REQ-024 HALT: DONE=1, INSTR_VALID=0, PC holds; START=1 -> PC<=0, FLAG_Q<=0, OVF_Q<=0, DONE<=0, next state RUN.
REQ-025 FLAG_WE/OVF_WE SHALL update FLAG_Q/OVF_Q one cycle later only when state is RUN; the write is kept in a branch or halt cycle.
REQ-026 LUT writes SHALL take effect only in IDLE or HALT; LUT_WE in RUN/BUBBLE is ignored.
REQ-027 START in RUN or BUBBLE SHALL be ignored.

Reset
REQ-028 RESET=1 SHALL immediately force IDLE, PC=0, FLAG_Q=0, OVF_Q=0, INSTR_VALID=0, BR_TAKEN=0, DONE=0, regardless of CLK, including mid-branch or mid-halt.
REQ-029 LUT contents SHALL be cleared to 0 by RESET.
REQ-030 First RUN cycle after reset release and START SHALL present PC=0.

Configuration
REQ-031 Macro RELATIVE_BRANCH_EN defined: BR_REL selects relative vs absolute per REQ-022.
REQ-032 Macro RELATIVE_BRANCH_EN undefined: BR_REL ignored, all branches absolute, no PC+offset adder synthesized.

Verification
REQ-033 Reset, START, 5 cycles no branch -> PC 0,1,2,3,4 with INSTR_VALID=1; FLAG_Q=OVF_Q=0.
REQ-034 LUT[3]=0x040 in IDLE; at PC=2 BRANCH_EN=1, BR_IDX=3, BR_REL=0 -> BR_TAKEN pulse, one BUBBLE cycle with INSTR_VALID=0, then PC=0x040, INSTR_VALID=1.
REQ-035 RELATIVE_BRANCH_EN defined, LUT[1]=0x3FE (-2), at PC=0x005 BR_REL=1 -> PC=0x003; at PC=0x001 -> PC=0x3FF (wrap).
REQ-036 PC=0x3FF sequential -> PC=0x000; HALT_REQ=1 and BRANCH_EN=1 same cycle -> DONE=1, PC held, BR_TAKEN=0.
REQ-037 FLAG_WE=1, FLAG_D=1 in BUBBLE -> FLAG_Q stays 0; same write in RUN -> FLAG_Q=1 next cycle; START in HALT -> FLAG_Q=0, PC=0.
REQ-038 RESET asserted asynchronously during BUBBLE -> all outputs zero before next CLK edge; LUT reads back 0.
